// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the memory bridge: state encoding, funct3 codes,
// byte-enable generation, store-lane replication and access legality.
package mem_bridge_pkg;

  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size lives in funct3[1:0]; the sign bit does not affect the lanes touched.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   be_gen = 4'b0001 << off;
      2'b01:   be_gen = off[1] ? 4'b1100 : 4'b0011;
      default: be_gen = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_rep(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3[1:0])
      2'b00:   wdata_rep = {4{wdata[7:0]}};
      2'b01:   wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  endfunction

  function automatic logic illegal_acc(input logic we, input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B:    illegal_acc = 1'b0;
      F3_BU:   illegal_acc = we;
      F3_H:    illegal_acc = off[0];
      F3_HU:   illegal_acc = we | off[0];
      F3_W:    illegal_acc = (off != 2'b00);
      default: illegal_acc = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_bridge_load_align.sv
// Combinational load lane select and sign/zero extension; kept standalone so a
// cache refill path can reuse the same extraction.
module load_align
  import mem_bridge_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] lane;

  always_comb begin
    lane = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    data = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   data = {24'h0, lane[7:0]};
      F3_H:    data = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   data = {16'h0, lane[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// Controller-side memory request to valid/ready bus bridge with byte steering.
// Define MEM_BRIDGE_TIMEOUT_EN to abort stalled bus cycles after TIMEOUT_CYCLES.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       ld_data;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  load_align u_load_align (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    off_d       = off_q;
    f3_d        = f3_q;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d       = req_addr[1:0];
          f3_d        = req_funct3;
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          mem_be_d    = req_we ? be_gen(req_funct3, req_addr[1:0]) : 4'b1111;
          mem_wdata_d = wdata_rep(req_funct3, req_wdata);
`ifdef MEM_BRIDGE_TIMEOUT_EN
          cnt_d       = '0;
`endif
          if (illegal_acc(req_we, req_funct3, req_addr[1:0])) begin
            state_d = ERR;
          end else begin
            state_d     = BUS;
            mem_valid_d = 1'b1;
          end
        end
      end
      BUS: begin
        // A completing mem_ready always beats a timeout in the same cycle.
        if (mem_ready) begin
          if (!mem_we_q) rdata_d = ld_data;
          mem_valid_d = 1'b0;
          state_d     = DONE;
        end
`ifdef MEM_BRIDGE_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          mem_valid_d = 1'b0;
          state_d     = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE) || (state_q == ERR);
  assign rsp_err   = (state_q == ERR);
  assign rsp_rdata = rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: loads, stores, illegal accesses, reset mid-bus
// and the stalled-bus behaviour of whichever build is compiled.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  mem_bridge #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
`else
  mem_bridge #(.TIMEOUT_CYCLES(255), .ADDR_W(32)) dut (
`endif
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; bridge must be idle.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    tick();
    req_valid  = 1'b0;
  endtask

  // Hold mem_ready low for 'waits' bus cycles, then complete with rdata.
  task automatic respond(input int waits, input logic [31:0] rdata);
    repeat (waits) tick();
    mem_rdata = rdata;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    // Reset
    repeat (2) tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_be",    mem_be, 0);
    check("rst_mem_addr",  mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    rst = 1'b1;
    tick();

    // Stray mem_ready while idle does nothing
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("idle_ready_rsp", rsp_valid, 0);
    check("idle_ready_mv",  mem_valid, 0);

    // lw 0x100, three wait cycles
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    check("lw_mem_valid", mem_valid, 1);
    check("lw_mem_addr",  mem_addr, 32'h100);
    check("lw_mem_be",    mem_be, 4'b1111);
    check("lw_mem_we",    mem_we, 0);
    check("lw_req_ready", req_ready, 0);
    repeat (3) begin
      tick();
      check("lw_wait_rsp", rsp_valid, 0);
      check("lw_wait_mv",  mem_valid, 1);
    end
    mem_rdata = 32'hDEADBEEF;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("lw_rsp_valid", rsp_valid, 1);
    check("lw_rsp_err",   rsp_err, 0);
    check("lw_rdata",     rsp_rdata, 32'hDEADBEEF);
    check("lw_mv_drop",   mem_valid, 0);
    tick();
    check("lw_back_idle", req_ready, 1);
    check("lw_rsp_clear", rsp_valid, 0);

    // lb / lbu / lh, zero wait
    issue(1'b0, 3'b000, 32'h103, 32'h0);
    check("lb_addr", mem_addr, 32'h100);
    respond(0, 32'h80FF_0000);
    check("lb_rsp",   rsp_valid, 1);
    check("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
    tick();
    issue(1'b0, 3'b100, 32'h103, 32'h0);
    respond(1, 32'h80FF_0000);
    check("lbu_rdata", rsp_rdata, 32'h0000_0080);
    tick();
    issue(1'b0, 3'b001, 32'h102, 32'h0);
    respond(0, 32'h80FF_0000);
    check("lh_rdata", rsp_rdata, 32'hFFFF_80FF);
    tick();

    // sb / sh
    issue(1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB);
    check("sb_addr",  mem_addr, 32'h200);
    check("sb_be",    mem_be, 4'b0010);
    check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    check("sb_we",    mem_we, 1);
    respond(2, 32'h5555_5555);
    check("sb_rsp",       rsp_valid, 1);
    check("sb_rdata_hold", rsp_rdata, 32'hFFFF_80FF);
    tick();
    issue(1'b1, 3'b001, 32'h202, 32'h1234_56AB);
    check("sh_be",    mem_be, 4'b1100);
    check("sh_wdata", mem_wdata, 32'h56AB_56AB);
    respond(0, 32'h0);
    check("sh_err", rsp_err, 0);
    tick();

    // Misaligned sw, illegal funct3, store-unsigned
    issue(1'b1, 3'b010, 32'h101, 32'hCAFE_F00D);
    check("sw_mis_mv",    mem_valid, 0);
    check("sw_mis_rsp",   rsp_valid, 1);
    check("sw_mis_err",   rsp_err, 1);
    check("sw_mis_rdata", rsp_rdata, 32'hFFFF_80FF);
    tick();
    check("sw_mis_idle", req_ready, 1);
    issue(1'b0, 3'b011, 32'h100, 32'h0);
    check("f3_011_rsp", rsp_valid, 1);
    check("f3_011_err", rsp_err, 1);
    check("f3_011_mv",  mem_valid, 0);
    tick();
    issue(1'b1, 3'b100, 32'h100, 32'h0);
    check("sbu_err", rsp_err, 1);
    tick();
    issue(1'b0, 3'b101, 32'h103, 32'h0);
    check("lhu_mis_err", rsp_err, 1);
    tick();

    // Reset in the middle of a bus cycle
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    check("rmid_mv_before", mem_valid, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rmid_mv",        mem_valid, 0);
    check("rmid_req_ready", req_ready, 1);
    check("rmid_rsp",       rsp_valid, 0);
    check("rmid_rdata",     rsp_rdata, 0);
    issue(1'b0, 3'b010, 32'h104, 32'h0);
    check("rmid_new_addr", mem_addr, 32'h104);
    respond(0, 32'h1234_5678);
    check("rmid_new_rsp",   rsp_valid, 1);
    check("rmid_new_rdata", rsp_rdata, 32'h1234_5678);
    tick();

`ifdef MEM_BRIDGE_TIMEOUT_EN
    // Stalled bus aborts after four bus cycles
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    repeat (3) tick();
    check("to_mv_hold", mem_valid, 1);
    check("to_no_rsp",  rsp_valid, 0);
    tick();
    check("to_rsp", rsp_valid, 1);
    check("to_err", rsp_err, 1);
    check("to_mv",  mem_valid, 0);
    tick();
`else
    // Stalled bus waits indefinitely
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    hi_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (mem_valid && !rsp_valid) hi_cnt++;
      tick();
    end
    check("stall_mv_cycles", hi_cnt, 100);
    respond(0, 32'hA5A5_A5A5);
    check("stall_done_err",   rsp_err, 0);
    check("stall_done_rdata", rsp_rdata, 32'hA5A5_A5A5);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
